// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: oversampling constants, receiver
//                state encoding and the 3-sample majority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Two-flop synchronizer for the serial line plus the sample
//                registers feeding the 3-sample majority vote. The vote is
//                valid during the tick where the sample counter is SAMPLE_HI.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       tick_16x,
    input  logic [3:0] cnt,
    output logic       rx_sync,
    output logic       bit_vote
);

    logic r_meta;
    logic r_sync;
    logic r_s_lo;
    logic r_s_mid;

    // Synchronize the asynchronous line; idle level is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
        end
    end

    // Capture the first two of the three mid-bit samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_lo  <= 1'b1;
            r_s_mid <= 1'b1;
        end else if (tick_16x) begin
            if (cnt == 4'(SAMPLE_LO))
                r_s_lo <= r_sync;
            if (cnt == 4'(SAMPLE_MID))
                r_s_mid <= r_sync;
        end
    end

    // Third sample is the live synchronized value on the SAMPLE_HI tick
    assign rx_sync  = r_sync;
    assign bit_vote = majority3(r_s_lo, r_s_mid, r_sync);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x oversampling UART receiver with majority voting, parity
//                and stop-bit checking, and a valid/ready output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [3:0] c_last_bit  = 4'(DATA_BITS - 1);
    localparam logic       c_last_stop = 1'(STOP_BITS - 1);
    localparam logic       c_par_odd   = 1'(PARITY_ODD);

    uart_rx_state_t       r_state;
    logic [3:0]           r_cnt;
    logic                 r_armed;
    logic [3:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_sync;
    logic w_vote;
    logic w_hi;
    logic w_last;
    logic w_done;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .tick_16x (tick_16x),
        .cnt      (r_cnt),
        .rx_sync  (w_sync),
        .bit_vote (w_vote)
    );

    assign w_hi   = (r_cnt == 4'(SAMPLE_HI));
    assign w_last = (r_cnt == 4'(OVERSAMPLE - 1));
    // Frame ends at mid-sample of the final stop bit, not at its end,
    // so the next start edge can be caught early
    assign w_done = tick_16x && (r_state == ST_STOP) && w_hi && (r_stop_cnt == c_last_stop);

    // Frame FSM, sample counter, bit counters and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else if (tick_16x) begin
            r_cnt <= r_cnt + 4'd1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    // A low line only counts as a start after it was seen high
                    if (w_sync) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_armed    <= 1'b0;
                        r_state    <= ST_START;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_frm_err  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_hi && w_vote) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hi)
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_last) begin
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_hi)
                        r_par_err <= ((^r_shift) ^ w_vote) != c_par_odd;
                    if (w_last)
                        r_state <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_hi) begin
                        if (!w_vote)
                            r_frm_err <= 1'b1;
                        if (r_stop_cnt == c_last_stop) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    if (w_last)
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output word and status; a completion wins over a same-cycle accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_done) begin
            r_rx_data    <= r_shift;
            r_rx_valid   <= 1'b1;
            r_parity_err <= r_par_err;
            r_frame_err  <= r_frm_err | ~w_vote;
            r_overrun    <= r_rx_valid & ~rx_ready;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are described as a
//                list of bit levels and played out 16 ticks per bit; expected
//                results come from the frame contents and the frame-length
//                formula. Two instances: 8N1 defaults and 8E2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_16x;
    logic       rx;
    logic       rx_p;
    logic       rx_ready;
    logic       rx_ready_p;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       parity_err, parity_err_p;
    logic       frame_err, frame_err_p;
    logic       overrun, overrun_p;
    logic       busy, busy_p;

    always #5 clk = ~clk;

    uart_rx u_dut (
        .clk        (clk),
        .reset      (reset),
        .tick_16x   (tick_16x),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    uart_rx #(
        .DATA_BITS  (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .STOP_BITS  (2)
    ) u_dut_p (
        .clk        (clk),
        .reset      (reset),
        .tick_16x   (tick_16x),
        .rx         (rx_p),
        .rx_data    (rx_data_p),
        .rx_valid   (rx_valid_p),
        .rx_ready   (rx_ready_p),
        .parity_err (parity_err_p),
        .frame_err  (frame_err_p),
        .overrun    (overrun_p),
        .busy       (busy_p)
    );

    // Selected instance view
    bit         use_p = 1'b0;
    logic [7:0] s_data;
    logic       s_valid, s_perr, s_ferr, s_ovr, s_busy;
    assign s_data  = use_p ? rx_data_p    : rx_data;
    assign s_valid = use_p ? rx_valid_p   : rx_valid;
    assign s_perr  = use_p ? parity_err_p : parity_err;
    assign s_ferr  = use_p ? frame_err_p  : frame_err;
    assign s_ovr   = use_p ? overrun_p    : overrun;
    assign s_busy  = use_p ? busy_p       : busy;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count words presented by the 8N1 instance
    int   words = 0;
    logic prev_valid = 1'b0;
    always @(posedge clk) begin
        prev_valid <= rx_valid;
        if (rx_valid && !prev_valid)
            words <= words + 1;
    end

    bit ready_on_tick = 1'b0;

    task automatic set_ready(input logic v);
        if (use_p) rx_ready_p = v;
        else       rx_ready   = v;
    endtask

    // One tick period (4 clk); the tick sees the level v
    task automatic drive_tick(input logic v);
        if (use_p) begin rx_p = v; rx = 1'b1; end
        else       begin rx = v; rx_p = 1'b1; end
        repeat (3) @(negedge clk);
        tick_16x = 1'b1;
        if (ready_on_tick) set_ready(1'b1);
        @(negedge clk);
        tick_16x = 1'b0;
        if (ready_on_tick) set_ready(1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_tick(1'b1);
    endtask

    task automatic accept();
        set_ready(1'b1);
        @(negedge clk);
        set_ready(1'b0);
    endtask

    logic lv_q[$];
    int   glitch_bit    = -1;
    int   done_tick     = -1;
    bit   ready_on_done = 1'b0;

    task automatic build_frame(input logic [7:0] data, input bit par_en, input logic par_bit,
                               input int n_stop, input logic [1:0] stops);
        lv_q.delete();
        lv_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv_q.push_back(data[i]);
        if (par_en) lv_q.push_back(par_bit);
        for (int i = 0; i < n_stop; i++) lv_q.push_back(stops[i]);
    endtask

    // Play the first n_bits bit periods; tick 0 is the start-detect tick
    task automatic play_frame(input int n_bits);
        int   k;
        logic v;
        k = 0;
        for (int j = 0; j < n_bits; j++) begin
            for (int t = 0; t < 16; t++) begin
                v = lv_q[j];
                if (j == glitch_bit && t == 9) v = ~v;
                ready_on_tick = ready_on_done && (k == done_tick);
                drive_tick(v);
                if (done_tick >= 0 && k == done_tick - 1 && !ready_on_done)
                    check("pre_done_valid", s_valid, 1'b0);
                if (done_tick >= 0 && k == done_tick)
                    check("done_valid", s_valid, 1'b1);
                k++;
            end
        end
        ready_on_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit par_en, input logic par_bit,
                              input int n_stop, input logic [1:0] stops, input int gap);
        build_frame(data, par_en, par_bit, n_stop, stops);
        play_frame(lv_q.size());
        idle(gap);
    endtask

    localparam int LEN_8N1 = 16 * (1 + 8 + 0 + 1 - 1) + 10;
    localparam int LEN_8E2 = 16 * (1 + 8 + 1 + 2 - 1) + 10;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         w0, r;
        bit         bad_par, m_valid;
        logic [1:0] stops;

        reset = 1'b1; tick_16x = 1'b0; rx = 1'b1; rx_p = 1'b1;
        rx_ready = 1'b0; rx_ready_p = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", rx_data, 0);
        reset = 1'b0;
        idle(4);
        check("post_rst_valid", rx_valid, 0);

        // Nominal 8N1 frame with completion timing
        done_tick = LEN_8N1;
        send_frame(8'hA5, 0, 0, 1, 2'b11, 2);
        done_tick = -1;
        check("nom_data", s_data, 8'hA5);
        check("nom_valid", s_valid, 1);
        check("nom_perr", s_perr, 0);
        check("nom_ferr", s_ferr, 0);
        check("nom_ovr", s_ovr, 0);
        accept();
        check("acc_valid", s_valid, 0);
        check("acc_data_hold", s_data, 8'hA5);

        // Short low glitch on an idle line
        for (int i = 0; i < 4; i++) drive_tick(1'b0);
        check("glitch_busy", s_busy, 1);
        idle(16);
        check("glitch_busy_end", s_busy, 0);
        check("glitch_valid", s_valid, 0);

        // Single-tick glitch on the middle sample of a random data bit
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom);
            glitch_bit = $urandom_range(1, 8);
            send_frame(b, 0, 0, 1, 2'b11, 2);
            glitch_bit = -1;
            check("dglitch_data", s_data, b);
            check("dglitch_valid", s_valid, 1);
            accept();
        end

        // Low stop bit followed by a held-low line
        w0 = words;
        build_frame(8'h55, 0, 0, 1, 2'b00);
        play_frame(lv_q.size());
        for (int i = 0; i < 40; i++) drive_tick(1'b0);
        check("hold_busy", s_busy, 0);
        idle(4);
        check("hold_words", words - w0, 1);
        check("hold_ferr", s_ferr, 1);
        check("hold_data", s_data, 8'h55);
        accept();
        send_frame(8'h12, 0, 0, 1, 2'b11, 2);
        check("rearm_data", s_data, 8'h12);
        check("rearm_ferr", s_ferr, 0);
        check("rearm_valid", s_valid, 1);
        accept();

        // Overrun on back-to-back frames with no accept
        send_frame(8'h11, 0, 0, 1, 2'b11, 0);
        send_frame(8'h22, 0, 0, 1, 2'b11, 2);
        check("ovr_data", s_data, 8'h22);
        check("ovr_flag", s_ovr, 1);
        check("ovr_valid", s_valid, 1);
        accept();
        // Accept coinciding with completion
        send_frame(8'h33, 0, 0, 1, 2'b11, 0);
        done_tick = LEN_8N1; ready_on_done = 1'b1;
        send_frame(8'h44, 0, 0, 1, 2'b11, 2);
        done_tick = -1; ready_on_done = 1'b0;
        check("same_data", s_data, 8'h44);
        check("same_ovr", s_ovr, 0);
        check("same_valid", s_valid, 1);
        accept();

        // Reset in the middle of a frame, with status outputs non-zero
        send_frame(8'h3C, 0, 0, 1, 2'b00, 4);
        build_frame(8'h96, 0, 0, 1, 2'b11);
        play_frame(4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", s_valid, 0);
        check("mid_rst_data", s_data, 0);
        check("mid_rst_ferr", s_ferr, 0);
        check("mid_rst_busy", s_busy, 0);
        drive_tick(1'b0);
        drive_tick(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive_tick(1'b0);
        check("unarmed_busy", s_busy, 0);
        idle(20);
        check("post_mid_valid", s_valid, 0);
        b = 8'($urandom);
        done_tick = LEN_8N1;
        send_frame(b, 0, 0, 1, 2'b11, 2);
        done_tick = -1;
        check("post_mid_data", s_data, b);
        accept();

        // 8E2 instance: forced parity error, then randomized frames
        use_p = 1'b1;
        idle(4);
        done_tick = LEN_8E2;
        send_frame(8'h03, 1, 1'b1, 2, 2'b11, 2);
        done_tick = -1;
        check("par_perr", s_perr, 1);
        check("par_data", s_data, 8'h03);
        check("par_ferr", s_ferr, 0);
        accept();
        m_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            b       = 8'($urandom);
            bad_par = ($urandom_range(0, 3) == 0);
            r       = $urandom_range(0, 3);
            stops   = (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : 2'b11;
            send_frame(b, 1, (^b) ^ bad_par, 2, stops, $urandom_range(1, 3));
            check("rnd_data", s_data, b);
            check("rnd_valid", s_valid, 1);
            check("rnd_perr", s_perr, bad_par);
            check("rnd_ferr", s_ferr, stops != 2'b11);
            check("rnd_ovr", s_ovr, m_valid);
            if ($urandom_range(0, 1) == 1) begin
                accept();
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
            end
        end

        use_p = 1'b0;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
